wb_queue: RTL and testbench
===========================

# wb_queue

Writeback buffer between the functional-unit completion paths and the physical register file's two write ports. Accepts up to two completed results per cycle, each a physical register index plus data, and holds them in a circular FIFO. Drains up to two entries per cycle, oldest first, onto the register file's A and B write ports. Absorbs bursts and cycles where the write ports are unavailable.

## Interface
- DEPTH, 8, number of entries; power of two, at least 4.
- XLEN, `XLEN, data width.
- PREG_NUMBER, `PREG_NUMBER, physical register count; index width IW = $clog2(PREG_NUMBER).
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in0_valid, in1_valid  input  1 each  completion valid; in0 is older than in1.
- in0_idx, in1_idx  input  IW each  destination physical register.
- in0_data, in1_data  input  XLEN each  result data.
- in_ready  output  1  at least 2 free entries this cycle.
- wb_stall  input  1  suppresses all dequeue this cycle.
- wra_en, wrb_en  output  1 each  register file write enables.
- wra_idx, wrb_idx  output  IW each  write indices.
- wra_data, wrb_data  output  XLEN each  write data.
- count  output  $clog2(DEPTH+1)  occupied entries.
- empty, full  output  1 each  count==0 / count==DEPTH.

## Operation
- State: entry array of {idx, data}, head pointer, tail pointer (each $clog2(DEPTH) bits, wrapping modulo DEPTH), count register.
- Enqueue:
  - Valid only when in_ready=1.
  - Valid inputs are compacted: in0 is written at tail, then in1 at the next slot.
  - If only in1_valid is set, in1 is written at tail.
  - tail and count advance by the number of valid inputs (0, 1 or 2).
  - When in_ready=0, inputs are ignored and the producer is required to hold them. Asserting valid while in_ready=0 is a protocol error, not checked.
- Dequeue, combinational from registered state:
  - wra_en = (count>=1) && !wb_stall; it presents entry[head].
  - wrb_en = (count>=2) && !wb_stall; it presents entry[head+1].
  - head advances, and count decreases, by wra_en+wrb_en at the clock edge.
- Ordering rule: port A always carries the older entry. If both entries target the same index, the register file's B-over-A write priority leaves the younger value. The same holds for duplicate indices in general: program order of completion is preserved.
- When wra_en or wrb_en is 0, the corresponding idx/data outputs are 0.
- in_ready = (DEPTH - count) >= 2, from the registered count only; same-cycle dequeue is not credited.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Entries enqueued this cycle are never dequeued this cycle; there is no bypass.
- Wrap-around: pointer arithmetic is modulo DEPTH. An entry pair may straddle index DEPTH-1 and index 0.

## Timing
- Reset, asynchronous and effective immediately:
  - head=0, tail=0, count=0.
  - empty=1, full=0, in_ready=1.
  - wra_en=wrb_en=0, all idx/data outputs 0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all buffered entries with no further writes.
- Latency: a result enqueued at edge N appears on wra_* or wrb_* during cycle N+1 (the cycle after edge N) if the queue was otherwise empty and wb_stall=0. It is written into the register file at edge N+1.
- Throughput: 2 enqueues and 2 dequeues per cycle sustained. At steady state with count≥2 and no stall, count stays constant.
- wb_stall is sampled combinationally. While held, the contents are frozen except for enqueues.
- full implies in_ready=0. in_ready is also 0 when count=DEPTH-1.

## Test plan
- Reset: assert reset mid-burst with count=5 -> immediately count=0, empty=1, in_ready=1, wra_en=wrb_en=0; no write in the following cycle.
- Single result: in0 = {idx 7, data 0xAB} into an empty queue -> next cycle wra_en=1, wra_idx=7, wra_data=0xAB, wrb_en=0; count returns to 0.
- Ordering and compaction:
  - Enqueue in1 only = {3, 0x11}, then in0/in1 = {4, 0x22}/{3, 0x33} with wb_stall=1 -> after releasing the stall, A={3, 0x11} and B={4, 0x22}, then A={3, 0x33}.
  - Register 3 finally holds 0x33.
- Fill and backpressure: with wb_stall=1, enqueue 2 per cycle for 4 cycles (DEPTH=8) -> count=8, full=1, in_ready=0 after the 4th edge. A valid asserted at count=7 has in_ready=0 and is not written.
- Wrap-around: enqueue and drain repeatedly until the pair entry[7]/entry[0] dequeues together -> correct idx/data on A then B; count is exact throughout.
- Concurrent enqueue and dequeue: count=3, enqueue 2, dequeue 2 in the same cycle -> count=3, and the newly enqueued entries are not output that cycle.

Source files
------------

// File: rtl/wb_queue_if.sv
// ---------------------------------------------------------------------------
// wb_queue_if
// Bundle of the signals between the completion paths, the writeback queue
// and the register file write ports.
//   in0_*/in1_*   two completion results per cycle (in0 older than in1)
//   in_ready      queue can accept two results this cycle
//   wb_stall      holds off all draining this cycle
//   wra_*/wrb_*   register file write ports A (older) and B (younger)
//   count/empty/full  occupancy status
// Modports: slave = the queue, master = the producer / register-file side.
// ---------------------------------------------------------------------------
interface wb_queue_if #(
    parameter int DEPTH       = 8,
    parameter int XLEN        = 32,
    parameter int PREG_NUMBER = 64
);
    localparam int IW = $clog2(PREG_NUMBER);
    localparam int CW = $clog2(DEPTH + 1);

    logic            in0_valid;
    logic [IW-1:0]   in0_idx;
    logic [XLEN-1:0] in0_data;
    logic            in1_valid;
    logic [IW-1:0]   in1_idx;
    logic [XLEN-1:0] in1_data;
    logic            in_ready;
    logic            wb_stall;
    logic            wra_en;
    logic [IW-1:0]   wra_idx;
    logic [XLEN-1:0] wra_data;
    logic            wrb_en;
    logic [IW-1:0]   wrb_idx;
    logic [XLEN-1:0] wrb_data;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;

    modport slave (
        input  in0_valid, in0_idx, in0_data,
        input  in1_valid, in1_idx, in1_data,
        input  wb_stall,
        output in_ready,
        output wra_en, wra_idx, wra_data,
        output wrb_en, wrb_idx, wrb_data,
        output count, empty, full
    );

    modport master (
        output in0_valid, in0_idx, in0_data,
        output in1_valid, in1_idx, in1_data,
        output wb_stall,
        input  in_ready,
        input  wra_en, wra_idx, wra_data,
        input  wrb_en, wrb_idx, wrb_data,
        input  count, empty, full
    );
endinterface

// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue
// Writeback buffer: a circular FIFO that accepts up to two completed results
// per cycle and drains up to two per cycle, oldest first, onto the register
// file's A and B write ports. Port A always carries the older entry so the
// register file's B-over-A priority preserves completion order.
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous, active-high; empties the queue immediately
//   bus    wb_queue_if.slave (enqueue, dequeue and status signals)
// ---------------------------------------------------------------------------
module wb_queue #(
    parameter int DEPTH       = 8,
    parameter int XLEN        = 32,
    parameter int PREG_NUMBER = 64
) (
    input  logic       clk,
    input  logic       reset,
    wb_queue_if.slave  bus
);
    localparam int IW = $clog2(PREG_NUMBER);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Entry storage; contents need no reset because count gates every read.
    logic [IW-1:0]   r_ent_idx  [DEPTH];
    logic [XLEN-1:0] r_ent_data [DEPTH];

    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_in_ready;
    logic            w_acc0;
    logic            w_acc1;
    logic            w_wp0_en;
    logic            w_wp1_en;
    logic [IW-1:0]   w_wp0_idx;
    logic [XLEN-1:0] w_wp0_data;
    logic [PW-1:0]   w_tail1;
    logic [PW-1:0]   w_head1;
    logic            w_deq_a;
    logic            w_deq_b;
    logic [1:0]      w_n_enq;
    logic [1:0]      w_n_deq;
    logic [CW-1:0]   w_count_next;

    // Readiness looks only at the registered count: a same-cycle dequeue is
    // deliberately not credited, keeping in_ready off the wb_stall path.
    assign w_in_ready = (r_count <= CW'(DEPTH - 2));

    assign w_acc0 = w_in_ready && bus.in0_valid;
    assign w_acc1 = w_in_ready && bus.in1_valid;

    // Compaction: the first slot (tail) takes in0 if present, else in1;
    // the second slot (tail+1) is used only when both inputs are valid.
    assign w_wp0_en   = w_acc0 || w_acc1;
    assign w_wp0_idx  = w_acc0 ? bus.in0_idx  : bus.in1_idx;
    assign w_wp0_data = w_acc0 ? bus.in0_data : bus.in1_data;
    assign w_wp1_en   = w_acc0 && w_acc1;

    // DEPTH is a power of two, so pointer wrap is the natural PW-bit overflow.
    assign w_tail1 = r_tail + PW'(1);
    assign w_head1 = r_head + PW'(1);

    assign w_deq_a = (r_count != '0)     && !bus.wb_stall;
    assign w_deq_b = (r_count >= CW'(2)) && !bus.wb_stall;

    assign w_n_enq = {1'b0, w_acc0} + {1'b0, w_acc1};
    assign w_n_deq = {1'b0, w_deq_a} + {1'b0, w_deq_b};

    assign w_count_next = r_count + CW'(w_n_enq) - CW'(w_n_deq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_n_deq);
            r_tail  <= r_tail + PW'(w_n_enq);
            r_count <= w_count_next;
        end
    end

    // Two write ports into distinct slots (tail and tail+1 never alias).
    always_ff @(posedge clk) begin
        if (w_wp0_en) begin
            r_ent_idx[r_tail]  <= w_wp0_idx;
            r_ent_data[r_tail] <= w_wp0_data;
        end
        if (w_wp1_en) begin
            r_ent_idx[w_tail1]  <= bus.in1_idx;
            r_ent_data[w_tail1] <= bus.in1_data;
        end
    end

    assign bus.in_ready = w_in_ready;

    // Disabled ports drive zeros so downstream never sees stale entries.
    assign bus.wra_en   = w_deq_a;
    assign bus.wra_idx  = w_deq_a ? r_ent_idx[r_head]  : '0;
    assign bus.wra_data = w_deq_a ? r_ent_data[r_head] : '0;
    assign bus.wrb_en   = w_deq_b;
    assign bus.wrb_idx  = w_deq_b ? r_ent_idx[w_head1]  : '0;
    assign bus.wrb_data = w_deq_b ? r_ent_data[w_head1] : '0;

    assign bus.count = r_count;
    assign bus.empty = (r_count == '0);
    assign bus.full  = (r_count == CW'(DEPTH));
endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int PREG  = 64;
    localparam int IW    = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .PREG_NUMBER(PREG)) bus ();

    wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PREG_NUMBER(PREG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IW-1:0]   idx;
        logic [XLEN-1:0] data;
    } ent_t;

    // Reference: a plain FIFO of accepted results in program order, and the
    // final register value expected from program order (last writer wins).
    ent_t            q[$];
    logic [XLEN-1:0] gold_rf [PREG];
    logic [XLEN-1:0] dut_rf  [PREG];

    int checks   = 0;
    int failures = 0;

    // Last observations taken inside step(), used by directed checks.
    logic            last_wra_en, last_wrb_en, last_full, last_in_ready;
    logic [IW-1:0]   last_wra_idx, last_wrb_idx;
    logic [XLEN-1:0] last_wra_data, last_wrb_data;
    logic [3:0]      last_count;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model just
    // before the edge, record register-file writes, advance the model.
    task automatic step(input logic v0, input logic [IW-1:0] i0, input logic [XLEN-1:0] d0,
                        input logic v1, input logic [IW-1:0] i1, input logic [XLEN-1:0] d1,
                        input logic stall);
        bit   rdy;
        int   n;
        int   ndeq;
        ent_t ea;
        ent_t eb;
        bus.in0_valid = v0; bus.in0_idx = i0; bus.in0_data = d0;
        bus.in1_valid = v1; bus.in1_idx = i1; bus.in1_data = d1;
        bus.wb_stall  = stall;
        #2;
        n   = q.size();
        rdy = (DEPTH - n) >= 2;
        ea  = (n >= 1 && !stall) ? q[0] : '0;
        eb  = (n >= 2 && !stall) ? q[1] : '0;
        chk("count",    64'(bus.count),  64'(n));
        chk("empty",    64'(bus.empty),  64'(n == 0));
        chk("full",     64'(bus.full),   64'(n == DEPTH));
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        chk("wra_en",   64'(bus.wra_en), 64'(n >= 1 && !stall));
        chk("wra_idx",  64'(bus.wra_idx),  64'(ea.idx));
        chk("wra_data", 64'(bus.wra_data), 64'(ea.data));
        chk("wrb_en",   64'(bus.wrb_en), 64'(n >= 2 && !stall));
        chk("wrb_idx",  64'(bus.wrb_idx),  64'(eb.idx));
        chk("wrb_data", 64'(bus.wrb_data), 64'(eb.data));
        last_wra_en = bus.wra_en; last_wra_idx = bus.wra_idx; last_wra_data = bus.wra_data;
        last_wrb_en = bus.wrb_en; last_wrb_idx = bus.wrb_idx; last_wrb_data = bus.wrb_data;
        last_count  = bus.count;  last_full = bus.full;       last_in_ready = bus.in_ready;
        // Register file semantics: A written first, B overrides on same index.
        if (bus.wra_en) dut_rf[bus.wra_idx] = bus.wra_data;
        if (bus.wrb_en) dut_rf[bus.wrb_idx] = bus.wrb_data;
        ndeq = stall ? 0 : ((n >= 2) ? 2 : n);
        for (int k = 0; k < ndeq; k++) void'(q.pop_front());
        if (rdy) begin
            if (v0) begin q.push_back('{i0, d0}); gold_rf[i0] = d0; end
            if (v1) begin q.push_back('{i1, d1}); gold_rf[i1] = d1; end
        end
        $display("t=%0t in0=%b in1=%b stall=%b count=%0d wra=%b/%0d wrb=%b/%0d",
                 $time, v0, v1, stall, bus.count, bus.wra_en, bus.wra_idx, bus.wrb_en, bus.wrb_idx);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic stall);
        step(1'b0, '0, '0, 1'b0, '0, '0, stall);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < PREG; r++) begin
            gold_rf[r] = '0;
            dut_rf[r]  = '0;
        end
        bus.in0_valid = 0; bus.in0_idx = '0; bus.in0_data = '0;
        bus.in1_valid = 0; bus.in1_idx = '0; bus.in1_data = '0;
        bus.wb_stall  = 0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_count",    64'(bus.count),    64'd0);
        chk("rst_empty",    64'(bus.empty),    64'd1);
        chk("rst_full",     64'(bus.full),     64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_wra_en",   64'(bus.wra_en),   64'd0);
        chk("rst_wrb_en",   64'(bus.wrb_en),   64'd0);
        chk("rst_wra_idx",  64'(bus.wra_idx),  64'd0);
        chk("rst_wrb_data", 64'(bus.wrb_data), 64'd0);
        reset = 1'b0;

        // Single result: one cycle latency on port A
        step(1'b1, 6'd7, 32'hAB, 1'b0, '0, '0, 1'b0);
        idle(1'b0);
        chk("single_wra_en",   64'(last_wra_en),   64'd1);
        chk("single_wra_idx",  64'(last_wra_idx),  64'd7);
        chk("single_wra_data", 64'(last_wra_data), 64'hAB);
        chk("single_wrb_en",   64'(last_wrb_en),   64'd0);
        idle(1'b0);
        chk("single_count0",   64'(last_count),    64'd0);

        // Ordering and compaction
        step(1'b0, '0, '0, 1'b1, 6'd3, 32'h11, 1'b1);
        step(1'b1, 6'd4, 32'h22, 1'b1, 6'd3, 32'h33, 1'b1);
        idle(1'b0);
        chk("ord_a_idx",  64'(last_wra_idx),  64'd3);
        chk("ord_a_data", 64'(last_wra_data), 64'h11);
        chk("ord_b_idx",  64'(last_wrb_idx),  64'd4);
        chk("ord_b_data", 64'(last_wrb_data), 64'h22);
        idle(1'b0);
        chk("ord_a2_idx",  64'(last_wra_idx),  64'd3);
        chk("ord_a2_data", 64'(last_wra_data), 64'h33);
        chk("ord_a2_b_en", 64'(last_wrb_en),   64'd0);
        chk("ord_rf3",     64'(dut_rf[3]),     64'h33);

        // Wrap-around: advance head/tail to slot 7, then a pair straddling 7/0
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 6'(5 + k), $urandom, 1'b0, '0, '0, 1'b0);
            idle(1'b0);
        end
        step(1'b1, 6'd10, 32'hA0A0, 1'b1, 6'd11, 32'hB1B1, 1'b0);
        idle(1'b0);
        chk("wrap_a_idx",  64'(last_wra_idx),  64'd10);
        chk("wrap_a_data", 64'(last_wra_data), 64'hA0A0);
        chk("wrap_b_idx",  64'(last_wrb_idx),  64'd11);
        chk("wrap_b_data", 64'(last_wrb_data), 64'hB1B1);

        // Fill to full under stall
        for (int k = 0; k < 4; k++)
            step(1'b1, 6'(40 + 2*k), $urandom, 1'b1, 6'(41 + 2*k), $urandom, 1'b1);
        step(1'b1, 6'd20, 32'hDEAD, 1'b0, '0, '0, 1'b1);
        chk("fill_count", 64'(last_count),    64'd8);
        chk("fill_full",  64'(last_full),     64'd1);
        chk("fill_ready", 64'(last_in_ready), 64'd0);
        for (int k = 0; k < 4; k++) idle(1'b0);

        // count = 7: in_ready low, offered result must be dropped
        for (int k = 0; k < 3; k++)
            step(1'b1, 6'(40 + 2*k), $urandom, 1'b1, 6'(41 + 2*k), $urandom, 1'b1);
        step(1'b1, 6'd46, $urandom, 1'b0, '0, '0, 1'b1);
        step(1'b1, 6'd21, 32'hBEEF, 1'b0, '0, '0, 1'b1);
        chk("c7_count", 64'(last_count),    64'd7);
        chk("c7_ready", 64'(last_in_ready), 64'd0);
        for (int k = 0; k < 4; k++) idle(1'b0);
        chk("c7_dropped", 64'(dut_rf[21]), 64'd0);

        // Concurrent enqueue and dequeue at count = 3
        step(1'b1, 6'd50, 32'h5050, 1'b1, 6'd51, 32'h5151, 1'b1);
        step(1'b1, 6'd52, 32'h5252, 1'b0, '0, '0, 1'b1);
        step(1'b1, 6'd53, 32'h5353, 1'b1, 6'd54, 32'h5454, 1'b0);
        chk("cc_count0", 64'(last_count),   64'd3);
        chk("cc_a_idx",  64'(last_wra_idx), 64'd50);
        chk("cc_b_idx",  64'(last_wrb_idx), 64'd51);
        idle(1'b0);
        chk("cc_count1", 64'(last_count),   64'd3);
        chk("cc_a2_idx", 64'(last_wra_idx), 64'd52);
        chk("cc_b2_idx", 64'(last_wrb_idx), 64'd53);
        for (int k = 0; k < 3; k++) idle(1'b0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 99) < 60), 6'($urandom_range(0, PREG - 1)), $urandom,
                 1'($urandom_range(0, 99) < 50), 6'($urandom_range(0, PREG - 1)), $urandom,
                 1'($urandom_range(0, 99) < 25));
        for (int k = 0; k < 12 && q.size() > 0; k++) idle(1'b0);
        idle(1'b0);
        chk("drain_empty", 64'(last_count), 64'd0);
        for (int r = 0; r < PREG; r++)
            chk($sformatf("rf[%0d]", r), 64'(dut_rf[r]), 64'(gold_rf[r]));

        // Asynchronous reset with five entries buffered
        step(1'b1, 6'd60, $urandom, 1'b1, 6'd61, $urandom, 1'b1);
        step(1'b1, 6'd62, $urandom, 1'b1, 6'd63, $urandom, 1'b1);
        step(1'b1, 6'd59, $urandom, 1'b0, '0, '0, 1'b1);
        bus.in0_valid = 0; bus.in1_valid = 0; bus.wb_stall = 0;
        #1;
        chk("mid_pre_count", 64'(bus.count), 64'd5);
        reset = 1'b1;
        #1;
        chk("mid_count",    64'(bus.count),    64'd0);
        chk("mid_empty",    64'(bus.empty),    64'd1);
        chk("mid_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_wra_en",   64'(bus.wra_en),   64'd0);
        chk("mid_wrb_en",   64'(bus.wrb_en),   64'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1'b0);
        chk("post_rst_wra_en", 64'(last_wra_en), 64'd0);
        chk("post_rst_wrb_en", 64'(last_wrb_en), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
